// File: rtl/cmdspi_burst.sv
`default_nettype none
// ============================================================================
//  Module      : cmdspi_burst
//  Description : SPI slave to register-bus bridge. Each frame carries a
//                read/write header bit, an AW-bit address and any number of
//                DW-bit data words. Writes are issued on we/wdat. Reads are
//                prefetched through re/rdat and shifted back on MISO.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmdspi_burst #(
    parameter int AW      = 7,
    parameter int DW      = 32,
    parameter int CPOL    = 0,
    parameter int CPHA    = 0,
    parameter int AUTOINC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CSN,
    input  logic          SCLK,
    input  logic          MOSI,
    output logic          MISO,
    output logic          we,
    output logic          re,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdat,
    input  logic [DW-1:0] rdat,
    output logic          busy
);

    // The receive shifter must hold either a full header or a full data word.
    localparam int         c_RX_W      = (AW + 1 > DW) ? AW + 1 : DW;
    localparam logic [5:0] c_HDR_BITS  = 6'(AW + 1);
    localparam logic [5:0] c_WORD_BITS = 6'(DW);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_csn_s1, r_csn_s2, r_csn_s3;
    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_mosi_s1, r_mosi_s2;

    logic [c_RX_W-1:0] r_rx;
    logic [DW-1:0]     r_tx;
    logic [5:0]        r_cnt;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdat;
    logic              r_rw;
    logic              r_skip;
    logic              r_we;
    logic              r_re;
    logic              r_re_d1;
    logic              r_re_d2;

    logic              w_csn_fall, w_csn_rise, w_act;
    logic              w_sclk_rise, w_sclk_fall, w_lead, w_trail;
    logic              w_sample, w_shift, w_last;
    logic [c_RX_W-1:0] w_rx_next;

    assign w_csn_fall  =  r_csn_s3 & ~r_csn_s2;
    assign w_csn_rise  = ~r_csn_s3 &  r_csn_s2;
    assign w_act       = ~r_csn_s3 & ~r_csn_s2 & (r_state != ST_IDLE);
    assign w_sclk_rise =  r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall = ~r_sclk_s2 &  r_sclk_s3;
    // Leading edge leaves the idle level, trailing edge returns to it.
    assign w_lead      = (CPOL != 0) ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = (CPOL != 0) ? w_sclk_rise : w_sclk_fall;
    assign w_sample    = w_act & ((CPHA != 0) ? w_trail : w_lead);
    assign w_shift     = w_act & ((CPHA != 0) ? w_lead  : w_trail);
    assign w_last      = w_sample & (r_cnt == 6'd1);
    assign w_rx_next   = {r_rx[c_RX_W-2:0], r_mosi_s2};

    assign MISO = r_tx[DW-1];
    assign we   = r_we;
    assign re   = r_re;
    assign addr = r_addr;
    assign wdat = r_wdat;
    assign busy = (r_state != ST_IDLE);

    // Bring the SPI pins into the clk domain; third stage feeds edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csn_s1  <= 1'b0;
            r_csn_s2  <= 1'b0;
            r_csn_s3  <= 1'b0;
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_csn_s1  <= CSN;
            r_csn_s2  <= r_csn_s1;
            r_csn_s3  <= r_csn_s2;
            r_sclk_s1 <= SCLK;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_mosi_s1 <= MOSI;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    // Frame phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Phase sequencing: CSN falling always restarts the header.
    always_comb begin
        w_state_next = r_state;
        if (w_csn_fall) begin
            w_state_next = ST_HEADER;
        end else if (w_csn_rise) begin
            w_state_next = ST_IDLE;
        end else if (w_last && (r_state == ST_HEADER)) begin
            w_state_next = ST_DATA;
        end
    end

    // Shift registers, bit counter, bus strobes and read-data prefetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx    <= '0;
            r_tx    <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdat  <= '0;
            r_rw    <= 1'b0;
            r_skip  <= 1'b0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_re_d1 <= 1'b0;
            r_re_d2 <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_re_d1 <= r_re;
            r_re_d2 <= r_re_d1;
            // Post-write increment lands one clk after the strobe.
            if (r_we && (AUTOINC != 0)) begin
                r_addr <= r_addr + AW'(1);
            end
            if (w_csn_fall) begin
                r_cnt  <= c_HDR_BITS;
                r_rx   <= '0;
                r_tx   <= '0;
                r_skip <= 1'b0;
            end else if (w_csn_rise) begin
                r_cnt  <= '0;
                r_tx   <= '0;
                r_skip <= 1'b0;
            end else begin
                // rdat is valid two clk after re; the next shift edge must
                // leave the freshly loaded MSB on MISO for the master.
                if (r_re_d2 && (r_state == ST_DATA) && r_rw) begin
                    r_tx   <= rdat;
                    r_skip <= 1'b1;
                end else if (w_shift) begin
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else begin
                        r_tx <= {r_tx[DW-2:0], 1'b0};
                    end
                end
                if (w_sample) begin
                    r_rx  <= w_rx_next;
                    r_cnt <= r_cnt - 6'd1;
                    if (w_last && (r_state == ST_HEADER)) begin
                        r_addr <= w_rx_next[AW-1:0];
                        r_rw   <= w_rx_next[AW];
                        r_re   <= w_rx_next[AW];
                        r_cnt  <= c_WORD_BITS;
                    end else if (w_last) begin
                        r_cnt <= c_WORD_BITS;
                        if (r_rw) begin
                            // Prefetch the next word even if the frame ends.
                            r_re <= 1'b1;
                            if (AUTOINC != 0) begin
                                r_addr <= r_addr + AW'(1);
                            end
                        end else begin
                            r_we   <= 1'b1;
                            r_wdat <= w_rx_next[DW-1:0];
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
